// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: data width, canonical NOP, and the
// {pc, instr} entry type passed from fetch to decode.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary before being fetched.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order circular FIFO of fetch entries between instruction memory and decode.
// Flush empties the queue and overrides a same-cycle push.
module fetch_buffer
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = push & ~flush;
    assign w_pop  = pop & ~flush & (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An empty queue presents an all-zero entry so idle outputs are deterministic.
    assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

    a_no_overflow: assert property (@(posedge clk) !(push && !flush && (r_count == CW'(DEPTH))))
        else $error("fetch_buffer: push while full");

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: owns the PC, tracks the one-cycle memory
// read in flight, and queues {pc, instr} entries for decode.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign_err
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OW = CW + 2;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight_valid;
    logic            r_misalign_err;

    logic [CW-1:0]   w_count;
    logic [OW-1:0]   w_occupancy;
    logic            w_pop;
    logic            w_issue;
    logic            w_flush;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    assign w_pop = if_valid & if_ready;

    // Slots already promised after this edge: buffered + in flight - leaving.
    // Issuing only while this is below depth guarantees every response has room.
    assign w_occupancy = OW'(w_count) + OW'(r_inflight_valid) - OW'(w_pop);
    assign w_issue     = ~r_misalign_err & ~redirect_valid & (w_occupancy < OW'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
            r_misalign_err   <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc       <= word_align(redirect_pc);
            r_inflight_valid <= 1'b0;
            r_misalign_err   <= |redirect_pc[1:0];
        end else if (w_issue) begin
            r_fetch_pc       <= r_fetch_pc + 32'd4;
            r_inflight_valid <= 1'b1;
            r_inflight_pc    <= r_fetch_pc;
        end else begin
            r_inflight_valid <= 1'b0;
        end
    end

    assign w_flush      = reset | redirect_valid;
    assign w_push_entry = '{pc: r_inflight_pc, instr: imem_instruction};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fetch_buffer (
        .clk   (clk),
        .push  (r_inflight_valid),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_push_entry),
        .count (w_count),
        .head  (w_head)
    );

    assign imem_pc      = r_fetch_pc;
    assign if_valid     = (w_count != '0) & ~redirect_valid;
    assign if_pc        = w_head.pc;
    assign if_instr     = w_head.instr;
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed latency/redirect scenarios plus a
// randomized ready/redirect run scored against an ordered-PC stream model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_pc;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .misalign_err     (misalign_err)
    );

    always #5 clk = ~clk;

    // Preloaded memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    always @(posedge clk) imem_instruction <= mem_word(imem_pc);

    // Inputs change 2 time units after the edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; if_ready = 1'b1;
        repeat (3) tick();
        #1;
        n_cmp++; if (imem_pc !== RESET_PC) begin n_bad++; $display("FAIL rst_imem_pc: got %h want %h", imem_pc, RESET_PC); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        n_cmp++; if (if_instr !== 32'h0) begin n_bad++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL rst_misalign: got %b want 0", misalign_err); end
        tick(); reset = 1'b0; #1;
        n_cmp++; if (imem_pc !== RESET_PC) begin n_bad++; $display("FAIL r0_imem_pc: got %h want %h", imem_pc, RESET_PC); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL r0_if_valid: got %b want 0", if_valid); end
        tick(); #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL r1_if_valid: got %b want 0", if_valid); end
        n_cmp++; if (imem_pc !== RESET_PC + 32'd4) begin n_bad++; $display("FAIL r1_imem_pc: got %h want %h", imem_pc, RESET_PC + 32'd4); end
        tick(); #1;
        n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL r2_if_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_pc !== RESET_PC) begin n_bad++; $display("FAIL r2_if_pc: got %h want %h", if_pc, RESET_PC); end
        n_cmp++; if (if_instr !== mem_word(RESET_PC)) begin n_bad++; $display("FAIL r2_if_instr: got %h want %h", if_instr, mem_word(RESET_PC)); end
        exp_pc = RESET_PC + 32'd4;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) begin
            tick(); #1;
            n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, if_pc, exp_pc); end
            n_cmp++; if (if_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, if_instr, mem_word(exp_pc)); end
            n_cmp++; if (imem_pc !== exp_pc + 32'd8) begin n_bad++; $display("FAIL stream_imem_pc[%0d]: got %h want %h", i, imem_pc, exp_pc + 32'd8); end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_pc, held_instr, held_imem;
        tick(); if_ready = 1'b0; #1;
        held_pc = if_pc; held_instr = if_instr; held_imem = imem_pc;
        n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL bp_first_pc: got %h want %h", if_pc, exp_pc); end
        n_cmp++; if (imem_pc !== exp_pc + 32'd8) begin n_bad++; $display("FAIL bp_imem_pc: got %h want %h", imem_pc, exp_pc + 32'd8); end
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_pc !== held_pc) begin n_bad++; $display("FAIL bp_pc_stable[%0d]: got %h want %h", i, if_pc, held_pc); end
            n_cmp++; if (if_instr !== held_instr) begin n_bad++; $display("FAIL bp_instr_stable[%0d]: got %h want %h", i, if_instr, held_instr); end
            n_cmp++; if (imem_pc !== held_imem) begin n_bad++; $display("FAIL bp_imem_frozen[%0d]: got %h want %h", i, imem_pc, held_imem); end
        end
        for (int i = 0; i < 6; i++) begin
            tick(); if_ready = 1'b1; #1;
            n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL bp_resume_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL bp_resume_pc[%0d]: got %h want %h", i, if_pc, exp_pc); end
            n_cmp++; if (if_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL bp_resume_instr[%0d]: got %h want %h", i, if_instr, mem_word(exp_pc)); end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_redirect_full();
        tick(); if_ready = 1'b0; #1;
        tick(); #1;
        n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rd_full_valid: got %b want 1", if_valid); end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; if_ready = 1'b1; #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rd_T_valid: got %b want 0", if_valid); end
        tick(); redirect_valid = 1'b0; #1;
        n_cmp++; if (imem_pc !== 32'h40) begin n_bad++; $display("FAIL rd_T1_imem_pc: got %h want 00000040", imem_pc); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rd_T1_valid: got %b want 0", if_valid); end
        tick(); #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rd_T2_valid: got %b want 0", if_valid); end
        exp_pc = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rd_stream_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL rd_stream_pc[%0d]: got %h want %h", i, if_pc, exp_pc); end
            n_cmp++; if (if_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL rd_stream_instr[%0d]: got %h want %h", i, if_instr, mem_word(exp_pc)); end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_misalign();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL mis_T_valid: got %b want 0", if_valid); end
        tick(); redirect_valid = 1'b0; #1;
        n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_err_set: got %b want 1", misalign_err); end
        n_cmp++; if (imem_pc !== 32'h40) begin n_bad++; $display("FAIL mis_imem_pc: got %h want 00000040", imem_pc); end
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL mis_hold_valid[%0d]: got %b want 0", i, if_valid); end
            n_cmp++; if (imem_pc !== 32'h40) begin n_bad++; $display("FAIL mis_hold_imem[%0d]: got %h want 00000040", i, imem_pc); end
            n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_hold_err[%0d]: got %b want 1", i, misalign_err); end
        end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
        tick(); redirect_valid = 1'b0; #1;
        n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_again_err: got %b want 1", misalign_err); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL mis_again_valid: got %b want 0", if_valid); end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
        n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_clear_T_err: got %b want 1", misalign_err); end
        tick(); redirect_valid = 1'b0; #1;
        n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL mis_clear_err: got %b want 0", misalign_err); end
        n_cmp++; if (imem_pc !== 32'h80) begin n_bad++; $display("FAIL mis_clear_imem: got %h want 00000080", imem_pc); end
        tick(); #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL mis_clear_T2_valid: got %b want 0", if_valid); end
        tick(); #1;
        n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL mis_clear_T3_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_pc !== 32'h80) begin n_bad++; $display("FAIL mis_clear_T3_pc: got %h want 00000080", if_pc); end
        exp_pc = 32'h84;
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        tick(); redirect_valid = 1'b0; #1;
        n_cmp++; if (imem_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_imem_T1: got %h want fffffffc", imem_pc); end
        tick(); #1;
        n_cmp++; if (imem_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_imem_T2: got %h want 00000000", imem_pc); end
        want = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_pc !== want) begin n_bad++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, if_pc, want); end
            n_cmp++; if (if_instr !== mem_word(want)) begin n_bad++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, if_instr, mem_word(want)); end
            want += 32'd4;
        end
        exp_pc = want;
    endtask

    task automatic test_reset_pulse();
        tick(); if_ready = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rp_full_valid: got %b want 1", if_valid); end
        tick(); reset = 1'b1; #1;
        tick(); reset = 1'b0; #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rp_valid: got %b want 0", if_valid); end
        n_cmp++; if (imem_pc !== RESET_PC) begin n_bad++; $display("FAIL rp_imem_pc: got %h want %h", imem_pc, RESET_PC); end
        tick(); if_ready = 1'b1; #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rp_r1_valid: got %b want 0", if_valid); end
        tick(); #1;
        n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rp_r2_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_pc !== RESET_PC) begin n_bad++; $display("FAIL rp_r2_pc: got %h want %h", if_pc, RESET_PC); end
        exp_pc = RESET_PC + 32'd4;
    endtask

    // Model: decode must see consecutive word PCs starting at the latest
    // redirect target, nothing while in misalign error, and a held entry
    // must not change while stalled.
    task automatic test_random();
        logic        m_err = 1'b0;
        logic        stalled = 1'b0;
        logic [31:0] hold_pc = '0, hold_instr = '0, target;
        int unsigned delivered = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            redirect_valid = ($urandom_range(0, 19) == 0);
            target = $urandom;
            if ($urandom_range(0, 7) == 0) target = 32'hFFFF_FFF0 | (target & 32'h0000_000F);
            if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;
            redirect_pc = target;
            if_ready = ($urandom_range(0, 9) < 7);
            #1;
            n_cmp++; if (misalign_err !== m_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, misalign_err, m_err); end
            if (redirect_valid || m_err) begin
                n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_valid_low[%0d]: got %b want 0", i, if_valid); end
            end else if (stalled) begin
                n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_hold_valid[%0d]: got %b want 1", i, if_valid); end
                n_cmp++; if (if_pc !== hold_pc) begin n_bad++; $display("FAIL rnd_hold_pc[%0d]: got %h want %h", i, if_pc, hold_pc); end
                n_cmp++; if (if_instr !== hold_instr) begin n_bad++; $display("FAIL rnd_hold_instr[%0d]: got %h want %h", i, if_instr, hold_instr); end
            end
            if (if_valid && if_ready) begin
                n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, if_pc, exp_pc); end
                n_cmp++; if (if_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, if_instr, mem_word(exp_pc)); end
                exp_pc += 32'd4;
                delivered++;
            end
            stalled = if_valid && !if_ready;
            hold_pc = if_pc;
            hold_instr = if_instr;
            if (redirect_valid) begin
                exp_pc = {target[31:2], 2'b00};
                m_err = |target[1:0];
            end
        end
        tick(); redirect_valid = 1'b0; if_ready = 1'b1; #1;
        n_cmp++; if (delivered < 50) begin n_bad++; $display("FAIL rnd_delivered: got %0d want >=50", delivered); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misalign();
        test_wrap();
        test_reset_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the RV32I core.
- Owns the program counter and drives `instructionmem`'s `pc` input.
- Accounts for that memory's one-cycle registered read latency.
- Pairs each returned word with its PC and hands {pc, instr} to decode through a valid/ready handshake.
- A small flushable buffer absorbs decode back-pressure and branch/jump redirects.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, entries in the fetch buffer; minimum 2 for full throughput.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- redirect_valid  input  1  taken branch/jump/trap redirect this cycle
- redirect_pc  input  32  redirect target
- imem_pc  output  32  byte address to instruction memory
- imem_instruction  input  32  word for the address presented on the previous cycle
- if_valid  output  1  fetch entry available to decode
- if_ready  input  1  decode accepts entry
- if_pc  output  32  PC of the entry
- if_instr  output  32  instruction of the entry
- misalign_err  output  1  sticky, set by a misaligned redirect

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - fetch_pc = RESET_PC
  - inflight_valid = 0
  - buffer count = 0
  - misalign_err = 0
  - if_valid = 0; if_pc and if_instr = 0
- imem_pc = fetch_pc (register output); there is no combinational path from redirect_pc.
- pop = if_valid & if_ready.
- issue = !misalign_err & !redirect_valid & (count + inflight_valid - pop < BUF_DEPTH).
- On issue:
  - inflight_valid <= 1
  - inflight_pc <= fetch_pc
  - fetch_pc <= fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0)
- No issue: fetch_pc holds and inflight_valid <= 0. The memory's read that cycle is discarded.
- Response: when inflight_valid = 1, {inflight_pc, imem_instruction} is pushed into the buffer that cycle.
- Buffer:
  - in-order FIFO; simultaneous push and pop allowed
  - head drives if_pc/if_instr
  - if_valid = (count != 0) & !redirect_valid
- Overflow is impossible by construction of issue. An assertion fires on push while full.
- Redirect (highest priority, cycle T):
  - buffer flushed
  - inflight_valid <= 0
  - fetch_pc <= {redirect_pc[31:2], 2'b00}
  - if_valid forced 0 in cycle T, so no handshake completes in T
- Latency:
  - target on imem_pc at T+1, instruction pushed at T+2, if_valid = 1 at T+3
  - after reset release (cycle R0 = first cycle with reset low): RESET_PC issued in R0, if_valid at R0+2
- Throughput: one instruction per cycle while if_ready is held high.
- Misaligned redirect (redirect_pc[1:0] != 0): misalign_err <= 1 and issue stops. A later aligned redirect clears misalign_err and resumes fetch. A misaligned redirect while already in error keeps it set.
- Back-pressure: if_valid/if_pc/if_instr stay stable while if_valid & !if_ready.
- Reset mid-operation: all state returns to its reset values the next cycle; buffered and in-flight entries are lost.
- No address bounds check. Memory size is the memory's concern.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN = 32
  - INSTR_NOP = 32'h0000_0013
  - packed struct fetch_entry_t {pc[31:0], instr[31:0]}
- Sub-module fetch_buffer, a parameterised FIFO of fetch_entry_t:
  - inputs: push, pop, flush
  - outputs: count, head
  - flush overrides push in the same cycle
- PC and issue logic stay in fetch_unit.

Test Plan:
- Reset with RESET_PC = 0, if_ready = 1, memory preloaded → imem_pc 0,4,8,… one per cycle; if_valid first at R0+2; if_pc 0,4,8,… back-to-back with the matching words.
- Stream, then if_ready = 0 for 5 cycles → count reaches 2, imem_pc frozen, outputs stable. Raise ready → PCs continue without gap or duplicate.
- Buffer full plus in-flight fetch, redirect to 0x40 → if_valid = 0 in redirect cycle, imem_pc = 0x40 next cycle, first accepted if_pc = 0x40, no stale PCs delivered.
- Redirect to 0x42 → misalign_err = 1, if_valid stays 0, imem_pc constant. Then redirect to 0x80 → err clears, if_pc 0x80 at T+3.
- Redirect to 0xFFFF_FFFC → if_pc sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Reset pulse (1 cycle) with buffer full → next cycle if_valid = 0, imem_pc = RESET_PC; stream restarts with if_pc = RESET_PC.
